pc_gen: RTL

- Fetch-stage program counter generator for the RISC-V core. It is the parametrised successor of the combinational PC incrementer.
- Holds the architectural fetch PC in a register and selects the next PC from these sources: sequential, redirect (branch/jump), trap vector, or return-address-stack prediction.
- Supports stall, detects misaligned redirect targets, and keeps a RAS_DEPTH-deep circular return address stack for call/return prediction.

---
 rtl/pc_gen_if.sv | 28 ++
 rtl/pc_gen.sv | 95 +++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the PC generator and its surroundings.
// The master drives the redirect/trap/RAS controls; the slave (pc_gen) returns the fetch PC and status.
interface pc_gen_if #(
  parameter int N = 32
);
  logic         stall_i;
  logic         redirect_i;
  logic [N-1:0] redirect_pc_i;
  logic         trap_i;
  logic [N-1:0] trap_vec_i;
  logic         call_i;
  logic         ret_i;
  logic [N-1:0] pc_o;
  logic [N-1:0] pc_plus4_o;
  logic         misalign_o;
  logic         ras_empty_o;
  logic         ras_full_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, trap_i, trap_vec_i, call_i, ret_i,
    input  pc_o, pc_plus4_o, misalign_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, trap_i, trap_vec_i, call_i, ret_i,
    output pc_o, pc_plus4_o, misalign_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: registered fetch PC with trap/redirect/stall/RAS-predicted next-PC
// selection and a circular return address stack that overwrites its oldest entry on overflow.
module pc_gen #(
  parameter int          N         = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_gen_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [N-1:0]  r_pc;
  logic          r_misalign;
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_ras [RAS_DEPTH];

  logic [N-1:0]  w_pc_plus4;
  logic [N-1:0]  w_pc_nxt;
  logic [PW-1:0] w_top_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_misalign_nxt;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_unused_tv;

  assign w_pc_plus4  = r_pc + N'(4);
  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == CW'(RAS_DEPTH));
  assign w_unused_tv = ^bus.trap_vec_i[1:0];

  always_comb begin
    w_pc_nxt       = w_pc_plus4;
    w_top_nxt      = r_top;
    w_cnt_nxt      = r_cnt;
    w_misalign_nxt = r_misalign;
    w_wr_en        = 1'b0;
    w_wr_idx       = r_top;
    if (bus.trap_i) begin
      w_pc_nxt       = {bus.trap_vec_i[N-1:2], 2'b00};
      w_misalign_nxt = 1'b0;
    end else if (bus.redirect_i) begin
      w_pc_nxt       = {bus.redirect_pc_i[N-1:2], 2'b00};
      w_misalign_nxt = |bus.redirect_pc_i[1:0];
    end else if (bus.stall_i) begin
      w_pc_nxt = r_pc;
    end else if (bus.ret_i && !w_empty) begin
      w_pc_nxt = r_ras[r_top];
      if (bus.call_i) begin
        // Call+return: swap the top entry in place, depth unchanged.
        w_wr_en  = 1'b1;
        w_wr_idx = r_top;
      end else begin
        w_top_nxt = r_top - PW'(1);
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end else if (bus.call_i) begin
      // When full, top+1 is the oldest slot, so the push recycles it.
      w_wr_en   = 1'b1;
      w_wr_idx  = r_top + PW'(1);
      w_top_nxt = r_top + PW'(1);
      if (!w_full) w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= N'(RESET_PC);
      r_misalign <= 1'b0;
      r_top      <= '0;
      r_cnt      <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
      r_top      <= w_top_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Stack contents are qualified by r_cnt, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_ras[w_wr_idx] <= w_pc_plus4;
  end

  assign bus.pc_o        = r_pc;
  assign bus.pc_plus4_o  = w_pc_plus4;
  assign bus.misalign_o  = r_misalign;
  assign bus.ras_empty_o = w_empty;
  assign bus.ras_full_o  = w_full;
endmodule
